// File: rtl/bit_serializer.sv
// bit_serializer: WIDTH-bit valid/ready words to a gapless serial bit stream.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit to each frame.
module bit_serializer #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             dout,
   output logic             dout_valid,
   output logic             last_bit,
   output logic             busy
);
`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int FL = WIDTH + 1;
`else
   localparam int FL = WIDTH;
`endif
   localparam int CW = $clog2(FL);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t        state, state_n;
   logic [FL-1:0] sh, sh_n, load;
   logic [CW-1:0] cnt, cnt_n;
   logic          xfer;

   // The frame is laid out in the shift register so the next bit always sits at the exit end.
`ifdef BIT_SERIALIZER_PARITY_EN
   assign load = MSB_FIRST ? {din, ^din} : {^din, din};
`else
   assign load = din;
`endif

   assign din_ready = (state == IDLE) || last_bit;
   assign xfer      = din_valid && din_ready;
   assign busy      = dout_valid;

   always_comb begin
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      if (xfer) begin
         state_n = SHIFT;
         sh_n    = load;
         cnt_n   = '0;
      end else if (last_bit) begin
         state_n = IDLE;
         sh_n    = '0;
         cnt_n   = '0;
      end else if (state == SHIFT) begin
         sh_n    = MSB_FIRST ? sh << 1 : sh >> 1;
         cnt_n   = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         sh         <= '0;
         cnt        <= '0;
         dout       <= IDLE_BIT;
         dout_valid <= 1'b0;
         last_bit   <= 1'b0;
      end else begin
         state      <= state_n;
         sh         <= sh_n;
         cnt        <= cnt_n;
         dout       <= (state_n == SHIFT) ? (MSB_FIRST ? sh_n[FL-1] : sh_n[0]) : IDLE_BIT;
         dout_valid <= state_n == SHIFT;
         last_bit   <= (state_n == SHIFT) && (cnt_n == CW'(FL - 1));
      end
   end
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: MSB-first and LSB-first serializers driven in lockstep and
// checked against a bit-queue model of the expected serial stream.
module tb_bit_serializer;
   localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FL   = W + PAR;
   localparam bit IDLE = 1'b0;

   logic         clk = 1'b0, reset = 1'b1, din_valid = 1'b0;
   logic [W-1:0] din = '0;
   logic         m_rdy, m_dout, m_dv, m_last, m_busy;
   logic         l_rdy, l_dout, l_dv, l_last, l_busy;
   int           checks = 0, failures = 0, nxfer = 0;
   logic [1:0]   qm[$], ql[$];
   logic         em_d, em_v, em_l, em_r, el_d, el_v, el_l, el_r;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE)) dut_m (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(m_rdy),
      .dout(m_dout), .dout_valid(m_dv), .last_bit(m_last), .busy(m_busy));

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE)) dut_l (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(l_rdy),
      .dout(l_dout), .dout_valid(l_dv), .last_bit(l_last), .busy(l_busy));

   // Emission order: first bit at index FL-1.
   function automatic logic [FL-1:0] frame(input logic [W-1:0] w, input bit msb);
      logic [FL-1:0] f;
      f = '0;
      for (int i = 0; i < W; i++) f[FL-1-i] = msb ? w[W-1-i] : w[i];
      if (PAR != 0) f[0] = ^w;
      return f;
   endfunction

   task automatic upd();
      em_v = qm.size() != 0;
      em_d = em_v ? qm[0][0] : IDLE;
      em_l = em_v && qm[0][1];
      em_r = !em_v || qm[0][1];
      el_v = ql.size() != 0;
      el_d = el_v ? ql[0][0] : IDLE;
      el_l = el_v && ql[0][1];
      el_r = !el_v || ql[0][1];
   endtask

   task automatic tick();
      logic [FL-1:0] f, g;
      bit x;
      @(posedge clk);
      x = !reset && din_valid && em_r;
      if (qm.size() != 0) void'(qm.pop_front());
      if (ql.size() != 0) void'(ql.pop_front());
      if (reset) begin
         qm.delete();
         ql.delete();
      end
      if (x) begin
         f = frame(din, 1'b1);
         g = frame(din, 1'b0);
         for (int i = 0; i < FL; i++) begin
            qm.push_back({i == FL - 1, f[FL-1-i]});
            ql.push_back({i == FL - 1, g[FL-1-i]});
         end
         nxfer++;
      end
      upd();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      checks += 2;
      if ({m_dout, m_dv, m_last, m_busy, m_rdy} !== {IDLE, 4'b0001}) begin
         failures++;
         $display("FAIL reset_hold_msb got=%b exp=%b", {m_dout, m_dv, m_last, m_busy, m_rdy}, {IDLE, 4'b0001});
      end
      if ({l_dout, l_dv, l_last, l_busy, l_rdy} !== {IDLE, 4'b0001}) begin
         failures++;
         $display("FAIL reset_hold_lsb got=%b exp=%b", {l_dout, l_dv, l_last, l_busy, l_rdy}, {IDLE, 4'b0001});
      end
      reset = 1'b0;
      repeat (10) begin
         tick();
         checks += 2;
         if ({m_dout, m_dv, m_last, m_busy, m_rdy} !== {em_d, em_v, em_l, em_v, em_r}) begin
            failures++;
            $display("FAIL idle_msb t=%0t got=%b exp=%b", $time, {m_dout, m_dv, m_last, m_busy, m_rdy}, {em_d, em_v, em_l, em_v, em_r});
         end
         if ({l_dout, l_dv, l_last, l_busy, l_rdy} !== {el_d, el_v, el_l, el_v, el_r}) begin
            failures++;
            $display("FAIL idle_lsb t=%0t got=%b exp=%b", $time, {l_dout, l_dv, l_last, l_busy, l_rdy}, {el_d, el_v, el_l, el_v, el_r});
         end
      end
   endtask

   task automatic test_single(input logic [W-1:0] word, input logic [7:0] exp_m, input logic [7:0] exp_l);
      logic [8:0] sm, sl, xm, xl;
      sm = '0;
      sl = '0;
      xm = (PAR != 0) ? {exp_m, ^word} : {1'b0, exp_m};
      xl = (PAR != 0) ? {exp_l, ^word} : {1'b0, exp_l};
      din = word;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      for (int i = 0; i <= FL; i++) begin
         din = W'($urandom);
         checks += 2;
         if ({m_dout, m_dv, m_last, m_busy, m_rdy} !== {em_d, em_v, em_l, em_v, em_r}) begin
            failures++;
            $display("FAIL single_msb word=%h bit=%0d got=%b exp=%b", word, i, {m_dout, m_dv, m_last, m_busy, m_rdy}, {em_d, em_v, em_l, em_v, em_r});
         end
         if ({l_dout, l_dv, l_last, l_busy, l_rdy} !== {el_d, el_v, el_l, el_v, el_r}) begin
            failures++;
            $display("FAIL single_lsb word=%h bit=%0d got=%b exp=%b", word, i, {l_dout, l_dv, l_last, l_busy, l_rdy}, {el_d, el_v, el_l, el_v, el_r});
         end
         if (i < FL) begin
            sm = {sm[7:0], m_dout};
            sl = {sl[7:0], l_dout};
            tick();
         end
      end
      checks += 2;
      if (sm !== xm) begin
         failures++;
         $display("FAIL single_seq_msb word=%h got=%b exp=%b", word, sm, xm);
      end
      if (sl !== xl) begin
         failures++;
         $display("FAIL single_seq_lsb word=%h got=%b exp=%b", word, sl, xl);
      end
   endtask

   task automatic test_back_to_back();
      logic [17:0] sm, sl, xm, xl;
      int n0, cur, best, low;
      sm = '0;
      sl = '0;
      cur = 0;
      best = 0;
      low = 0;
      xm = (PAR != 0) ? {8'h0A, 1'b0, 8'h0A, 1'b0} : {2'b00, 16'h0A0A};
      xl = (PAR != 0) ? {8'h50, 1'b0, 8'h50, 1'b0} : {2'b00, 16'h5050};
      n0 = nxfer;
      din = 8'h0A;
      din_valid = 1'b1;
      repeat (2 * FL + 3) begin
         tick();
         if (nxfer - n0 >= 2) din_valid = 1'b0;
         checks += 2;
         if ({m_dout, m_dv, m_last, m_busy, m_rdy} !== {em_d, em_v, em_l, em_v, em_r}) begin
            failures++;
            $display("FAIL b2b_msb t=%0t got=%b exp=%b", $time, {m_dout, m_dv, m_last, m_busy, m_rdy}, {em_d, em_v, em_l, em_v, em_r});
         end
         if ({l_dout, l_dv, l_last, l_busy, l_rdy} !== {el_d, el_v, el_l, el_v, el_r}) begin
            failures++;
            $display("FAIL b2b_lsb t=%0t got=%b exp=%b", $time, {l_dout, l_dv, l_last, l_busy, l_rdy}, {el_d, el_v, el_l, el_v, el_r});
         end
         if (m_dv) begin
            sm = {sm[16:0], m_dout};
            sl = {sl[16:0], l_dout};
         end
         cur = m_dv ? cur + 1 : 0;
         if (cur > best) best = cur;
         if (!m_rdy) low++;
      end
      checks += 4;
      if (best != 2 * FL) begin
         failures++;
         $display("FAIL b2b_run got=%0d exp=%0d", best, 2 * FL);
      end
      if (low != 2 * (FL - 1)) begin
         failures++;
         $display("FAIL b2b_ready_low got=%0d exp=%0d", low, 2 * (FL - 1));
      end
      if (sm !== xm) begin
         failures++;
         $display("FAIL b2b_seq_msb got=%b exp=%b", sm, xm);
      end
      if (sl !== xl) begin
         failures++;
         $display("FAIL b2b_seq_lsb got=%b exp=%b", sl, xl);
      end
   endtask

   task automatic test_random();
      int n0;
      bit took;
      n0 = nxfer;
      for (int c = 0; c < 400; c++) begin
         took = nxfer != n0;
         n0 = nxfer;
         if (!din_valid || took) begin
            din_valid = $urandom_range(0, 2) != 0;
            din = W'($urandom);
         end
         tick();
         checks += 2;
         if ({m_dout, m_dv, m_last, m_busy, m_rdy} !== {em_d, em_v, em_l, em_v, em_r}) begin
            failures++;
            $display("FAIL random_msb cyc=%0d got=%b exp=%b", c, {m_dout, m_dv, m_last, m_busy, m_rdy}, {em_d, em_v, em_l, em_v, em_r});
         end
         if ({l_dout, l_dv, l_last, l_busy, l_rdy} !== {el_d, el_v, el_l, el_v, el_r}) begin
            failures++;
            $display("FAIL random_lsb cyc=%0d got=%b exp=%b", c, {l_dout, l_dv, l_last, l_busy, l_rdy}, {el_d, el_v, el_l, el_v, el_r});
         end
      end
      din_valid = 1'b0;
      repeat (FL + 1) tick();
   endtask

   task automatic test_async_reset();
      din = 8'hFF;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if ({m_dout, m_dv, m_busy} !== 3'b111) begin
         failures++;
         $display("FAIL arst_pre got=%b exp=111", {m_dout, m_dv, m_busy});
      end
      #2 reset = 1'b1;
      #1;
      checks += 2;
      if ({m_dout, m_dv, m_last, m_busy, m_rdy} !== {IDLE, 4'b0001}) begin
         failures++;
         $display("FAIL arst_now_msb got=%b exp=%b", {m_dout, m_dv, m_last, m_busy, m_rdy}, {IDLE, 4'b0001});
      end
      if ({l_dout, l_dv, l_last, l_busy, l_rdy} !== {IDLE, 4'b0001}) begin
         failures++;
         $display("FAIL arst_now_lsb got=%b exp=%b", {l_dout, l_dv, l_last, l_busy, l_rdy}, {IDLE, 4'b0001});
      end
      tick();
      reset = 1'b0;
      repeat (FL + 2) begin
         tick();
         checks += 2;
         if ({m_dout, m_dv, m_last, m_busy, m_rdy} !== {em_d, em_v, em_l, em_v, em_r}) begin
            failures++;
            $display("FAIL arst_after_msb t=%0t got=%b exp=%b", $time, {m_dout, m_dv, m_last, m_busy, m_rdy}, {em_d, em_v, em_l, em_v, em_r});
         end
         if ({l_dout, l_dv, l_last, l_busy, l_rdy} !== {el_d, el_v, el_l, el_v, el_r}) begin
            failures++;
            $display("FAIL arst_after_lsb t=%0t got=%b exp=%b", $time, {l_dout, l_dv, l_last, l_busy, l_rdy}, {el_d, el_v, el_l, el_v, el_r});
         end
      end
   endtask

   initial begin
      upd();
      test_reset();
      test_single(8'hA5, 8'hA5, 8'hA5);
      test_single(8'h01, 8'h01, 8'h80);
      test_single(8'h07, 8'h07, 8'hE0);
      test_back_to_back();
      test_random();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
